ysyx_2070017_idu_alu: RTL and testbench

YSYX_2070017_IDU_ALU -- requirements
Module: ysyx_2070017_idu_alu

---
 rtl/ysyx_2070017_idu_alu_pkg.sv | 18 +
 rtl/ysyx_24070017_MuxKey.sv | 27 ++
 rtl/ysyx_2070017_idu_alu.sv | 128 ++++++++++++
 tb/tb_ysyx_2070017_idu_alu.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/ysyx_2070017_idu_alu_pkg.sv
// Shared constants for the decode/ALU slice: datapath width and RV32I opcodes.
package ysyx_2070017_idu_alu_pkg;

  localparam int unsigned WORD_LENGTH = 32;
  localparam int unsigned INST_W      = 32;
  localparam int unsigned OPCODE_W    = 7;

  localparam logic [OPCODE_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/ysyx_24070017_MuxKey.sv
// Generic key-match mux.
//   key : selector compared against every table key
//   lut : NR_KEY packed entries, entry i = lut[i*(KEY_LEN+DATA_LEN) +: ...] = {key_i, data_i}
//   out : data paired with the matching key, zero when nothing matches
module ysyx_24070017_MuxKey #(
  parameter int unsigned NR_KEY   = 2,
  parameter int unsigned KEY_LEN  = 1,
  parameter int unsigned DATA_LEN = 1
) (
  input  logic [KEY_LEN-1:0]                     key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]   lut,
  output logic [DATA_LEN-1:0]                    out
);

  localparam int unsigned ENTRY_W = KEY_LEN + DATA_LEN;

  // Keys are expected to be unique; zero is the no-match default.
  always_comb begin
    out = '0;
    for (int i = 0; i < int'(NR_KEY); i++) begin
      if (lut[i*ENTRY_W+DATA_LEN +: KEY_LEN] == key) begin
        out = lut[i*ENTRY_W +: DATA_LEN];
      end
    end
  end

endmodule

// File: rtl/ysyx_2070017_idu_alu.sv
// RV32I field/immediate decoder feeding a single integer ALU.
//   clk, rst           : clock, asynchronous active-high reset (result_q only)
//   inst, pc           : instruction word and its address
//   rs1_data, rs2_data : register operands
//   opcode..funct7     : raw instruction fields (combinational)
//   immI..immJ         : sign-extended immediates (combinational)
//   alu_result         : combinational ALU output
//   result_q           : alu_result captured every rising edge
module ysyx_2070017_idu_alu #(
  parameter int unsigned WORD_LENGTH = ysyx_2070017_idu_alu_pkg::WORD_LENGTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            inst,
  input  logic [WORD_LENGTH-1:0] pc,
  input  logic [WORD_LENGTH-1:0] rs1_data,
  input  logic [WORD_LENGTH-1:0] rs2_data,
  output logic [6:0]             opcode,
  output logic [4:0]             rd,
  output logic [4:0]             rs1,
  output logic [4:0]             rs2,
  output logic [2:0]             funct3,
  output logic [6:0]             funct7,
  output logic [WORD_LENGTH-1:0] immI,
  output logic [WORD_LENGTH-1:0] immS,
  output logic [WORD_LENGTH-1:0] immB,
  output logic [WORD_LENGTH-1:0] immU,
  output logic [WORD_LENGTH-1:0] immJ,
  output logic [WORD_LENGTH-1:0] alu_result,
  output logic [WORD_LENGTH-1:0] result_q
);

  import ysyx_2070017_idu_alu_pkg::*;

  localparam int unsigned NR_SRC = 9;
  localparam int unsigned KEY_W  = OPCODE_W;

  logic [WORD_LENGTH-1:0] src1;
  logic [WORD_LENGTH-1:0] src2;
  logic [2:0]             eff_funct3;
  logic                   do_sub;
  logic [4:0]             shamt;

  // Raw fields.
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign rs1    = inst[19:15];
  assign funct3 = inst[14:12];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  // Immediates, sign-extended from inst[31] via signed width casts.
  assign immI = WORD_LENGTH'($signed(inst[31:20]));
  assign immS = WORD_LENGTH'($signed({inst[31:25], inst[11:7]}));
  assign immB = WORD_LENGTH'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign immJ = WORD_LENGTH'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
  assign immU = WORD_LENGTH'($signed({inst[31:12], 12'b0}));

  // Operand 1 select; LUI and unknown opcodes read zero.
  ysyx_24070017_MuxKey #(
    .NR_KEY  (NR_SRC),
    .KEY_LEN (KEY_W),
    .DATA_LEN(WORD_LENGTH)
  ) u_src1_mux (
    .key(opcode),
    .lut({OPC_LUI,    {WORD_LENGTH{1'b0}},
          OPC_AUIPC,  pc,
          OPC_JAL,    pc,
          OPC_BRANCH, pc,
          OPC_JALR,   rs1_data,
          OPC_OP_IMM, rs1_data,
          OPC_OP,     rs1_data,
          OPC_LOAD,   rs1_data,
          OPC_STORE,  rs1_data}),
    .out(src1)
  );

  // Operand 2 select; LUI and unknown opcodes read zero.
  ysyx_24070017_MuxKey #(
    .NR_KEY  (NR_SRC),
    .KEY_LEN (KEY_W),
    .DATA_LEN(WORD_LENGTH)
  ) u_src2_mux (
    .key(opcode),
    .lut({OPC_LUI,    {WORD_LENGTH{1'b0}},
          OPC_AUIPC,  immU,
          OPC_JAL,    immJ,
          OPC_JALR,   immI,
          OPC_OP_IMM, immI,
          OPC_LOAD,   immI,
          OPC_BRANCH, immB,
          OPC_STORE,  immS,
          OPC_OP,     rs2_data}),
    .out(src2)
  );

  // Only OP/OP_IMM use funct3; everything else is an address-style add.
  assign eff_funct3 = (opcode == OPC_OP || opcode == OPC_OP_IMM) ? funct3 : 3'b000;
  // inst[30] selects sub only for register-register ops; addi ignores it.
  assign do_sub     = (opcode == OPC_OP) && funct7[5];
  assign shamt      = src2[4:0];

  // ALU.
  always_comb begin
    alu_result = '0;
    unique case (eff_funct3)
      3'b000: alu_result = do_sub ? (src1 - src2) : (src1 + src2);
      3'b001: alu_result = src1 << shamt;
      3'b010: alu_result[0] = $signed(src1) < $signed(src2);
      3'b011: alu_result[0] = src1 < src2;
      3'b100: alu_result = src1 ^ src2;
      3'b101: alu_result = funct7[5] ? WORD_LENGTH'($signed(src1) >>> shamt) : (src1 >> shamt);
      3'b110: alu_result = src1 | src2;
      3'b111: alu_result = src1 & src2;
      default: alu_result = '0;
    endcase
  end

  // Result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
    end else begin
      result_q <= alu_result;
    end
  end

endmodule

// File: tb/tb_ysyx_2070017_idu_alu.sv
// Self-checking bench: directed vectors plus random instructions against an
// arithmetic reference model of RV32I decode/ALU semantics.
module tb_ysyx_2070017_idu_alu;

  logic        clk;
  logic        rst;
  logic [31:0] inst, pc, rs1_data, rs2_data;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] immI, immS, immB, immU, immJ, alu_result, result_q;

  int checks   = 0;
  int failures = 0;

  ysyx_2070017_idu_alu #(.WORD_LENGTH(32)) dut (
    .clk(clk), .rst(rst), .inst(inst), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7),
    .immI(immI), .immS(immS), .immB(immB), .immU(immU), .immJ(immJ),
    .alu_result(alu_result), .result_q(result_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Immediates built by shifting/masking the signed instruction word.
  function automatic void ref_imm(input logic [31:0] i,
                                  output logic [31:0] ii, output logic [31:0] is,
                                  output logic [31:0] ib, output logic [31:0] iu,
                                  output logic [31:0] ij);
    int si;
    si = i;
    ii = 32'(si >>> 20);
    is = 32'((si >>> 25) << 5) | 32'(i[11:7]);
    ib = 32'((si >>> 31) << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
    ij = 32'((si >>> 31) << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
    iu = i & 32'hFFFF_F000;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [31:0] i, input logic [31:0] p,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ii, is, ib, iu, ij, s1, s2;
    logic [2:0]  f;
    int          sa, sb;
    int unsigned sh;
    ref_imm(i, ii, is, ib, iu, ij);
    s1 = 0; s2 = 0; f = 3'd0;
    case (i[6:0])
      7'b0010111: begin s1 = p; s2 = iu; end
      7'b1101111: begin s1 = p; s2 = ij; end
      7'b1100011: begin s1 = p; s2 = ib; end
      7'b1100111: begin s1 = a; s2 = ii; end
      7'b0000011: begin s1 = a; s2 = ii; end
      7'b0100011: begin s1 = a; s2 = is; end
      7'b0010011: begin s1 = a; s2 = ii; f = i[14:12]; end
      7'b0110011: begin s1 = a; s2 = b;  f = i[14:12]; end
      default:    begin s1 = 0; s2 = 0; end
    endcase
    sa = s1; sb = s2; sh = s2 % 32;
    case (f)
      3'd0: return (i[6:0] == 7'b0110011 && i[30]) ? s1 - s2 : s1 + s2;
      3'd1: return s1 << sh;
      3'd2: return (sa < sb) ? 32'd1 : 32'd0;
      3'd3: return (s1 < s2) ? 32'd1 : 32'd0;
      3'd4: return s1 ^ s2;
      3'd5: return i[30] ? 32'(sa >>> sh) : s1 >> sh;
      3'd6: return s1 | s2;
      default: return s1 & s2;
    endcase
  endfunction

  // Drive a new instruction mid-cycle and let combinational outputs settle.
  task automatic apply(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    inst = i; pc = p; rs1_data = a; rs2_data = b;
    #1;
  endtask

  task automatic tick_check_q(input string tag, input logic [31:0] exp);
    @(posedge clk);
    #1;
    check(tag, result_q, exp);
  endtask

  logic [6:0] opc_tbl [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                               7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1111111};

  initial begin
    logic [31:0] ei, es, eb, eu, ej, exp, ri;
    rst = 1'b1; inst = 0; pc = 0; rs1_data = 0; rs2_data = 0;
    #2;
    check("reset_q", result_q, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // addi x1,x0,5
    apply(32'h0050_0093, 32'h0, 32'd0, 32'd0);
    check("addi_opcode", 32'(opcode), 32'h13);
    check("addi_rd",     32'(rd),     32'd1);
    check("addi_immI",   immI,        32'd5);
    check("addi_alu",    alu_result,  32'd5);
    tick_check_q("addi_q", 32'd5);

    // Async reset between edges, hold, then reload on first edge after release.
    rst = 1'b1;
    #1;
    check("rst_async_q", result_q, 32'd0);
    check("rst_alu_unaffected", alu_result, 32'd5);
    tick_check_q("rst_hold_q", 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick_check_q("rst_release_q", 32'd5);

    apply(32'h4020_8033, 32'h0, 32'd10, 32'd3);
    check("sub", alu_result, 32'd7);
    apply(32'h4010_D093, 32'h0, 32'h8000_0000, 32'd0);
    check("srai", alu_result, 32'hC000_0000);
    apply(32'h0020_A1B3, 32'h0, 32'hFFFF_FFFF, 32'd1);
    check("slt", alu_result, 32'd1);
    apply(32'h0020_B1B3, 32'h0, 32'hFFFF_FFFF, 32'd1);
    check("sltu", alu_result, 32'd0);
    apply(32'h0000_1097, 32'h8000_0000, 32'd0, 32'd0);
    check("auipc_immU", immU, 32'h0000_1000);
    check("auipc_alu", alu_result, 32'h8000_1000);
    apply(32'h0000_0000, 32'h8000_0000, 32'd7, 32'd9);
    check("zero_inst", alu_result, 32'd0);
    apply(32'h0011_00E7, 32'h0, 32'd4, 32'd0);
    check("jalr_bit0_kept", alu_result, 32'd5);
    apply(32'h4000_0093, 32'h0, 32'd10, 32'd0);
    check("addi_bit30_add", alu_result, 32'h40A);
    apply(32'h1234_52B7, 32'h100, 32'd11, 32'd22);
    check("lui_zero", alu_result, 32'd0);

    // Random instructions with a random opcode from the table.
    for (int n = 0; n < 200; n++) begin
      ri = $urandom;
      ri[6:0] = opc_tbl[$urandom_range(0, 9)];
      apply(ri, $urandom, $urandom, (n % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom);
      ref_imm(ri, ei, es, eb, eu, ej);
      exp = ref_alu(ri, pc, rs1_data, rs2_data);
      check("rnd_opcode", 32'(opcode), 32'(ri[6:0]));
      check("rnd_rd",     32'(rd),     32'(ri[11:7]));
      check("rnd_rs1",    32'(rs1),    32'(ri[19:15]));
      check("rnd_rs2",    32'(rs2),    32'(ri[24:20]));
      check("rnd_funct3", 32'(funct3), 32'(ri[14:12]));
      check("rnd_funct7", 32'(funct7), 32'(ri[31:25]));
      check("rnd_immI", immI, ei);
      check("rnd_immS", immS, es);
      check("rnd_immB", immB, eb);
      check("rnd_immU", immU, eu);
      check("rnd_immJ", immJ, ej);
      check("rnd_alu",  alu_result, exp);
      tick_check_q("rnd_q", exp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
